joy_md_scanner: RTL and testbench

//  Sequencer for the Megadrive DB9 splitter on the user port: drives SELECT (joy_mdsel) and the

---
 rtl/joy_pkg.sv | 32 +++
 rtl/joy_md_decode.sv | 67 ++++++
 rtl/joy_md_scanner.sv | 164 ++++++++++++++++
 tb/tb_joy_md_scanner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared types and bit/pin indices for the Megadrive DB9 splitter scanner.
package joy_pkg;

    typedef enum logic [1:0] {
        StGap,
        StPhase,
        StCommit
    } state_e;

    // Joystick word bit positions (active high)
    localparam int unsigned JOY_R     = 0;
    localparam int unsigned JOY_L     = 1;
    localparam int unsigned JOY_D     = 2;
    localparam int unsigned JOY_U     = 3;
    localparam int unsigned JOY_A     = 4;
    localparam int unsigned JOY_B     = 5;
    localparam int unsigned JOY_C     = 6;
    localparam int unsigned JOY_START = 7;
    localparam int unsigned JOY_X     = 8;
    localparam int unsigned JOY_Y     = 9;
    localparam int unsigned JOY_Z     = 10;
    localparam int unsigned JOY_MODE  = 11;

    // Raw pin positions in joy_in
    localparam int unsigned PIN_UP    = 0;
    localparam int unsigned PIN_DOWN  = 1;
    localparam int unsigned PIN_LEFT  = 2;
    localparam int unsigned PIN_RIGHT = 3;
    localparam int unsigned PIN_6     = 4;
    localparam int unsigned PIN_9     = 5;

endpackage

// File: rtl/joy_md_decode.sv
// Per-port shadow registers: captures pad pins at each sampled phase and builds the
// joystick word plus present/six-button flags for the next commit.
module joy_md_decode
    import joy_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_strobe,
    input  logic [2:0]  i_phase,
    input  logic [5:0]  i_pins,
    output logic [15:0] o_word,
    output logic        o_present,
    output logic        o_six
);

    logic [5:0]  w_act;
    logic [11:0] r_word;
    logic        r_present;
    logic        r_six;

    assign w_act = ~i_pins;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word    <= '0;
            r_present <= 1'b0;
            r_six     <= 1'b0;
        end else if (i_clear) begin
            r_word    <= '0;
            r_present <= 1'b0;
            r_six     <= 1'b0;
        end else if (i_strobe) begin
            case (i_phase)
                3'd0: begin
                    r_word[JOY_U] <= w_act[PIN_UP];
                    r_word[JOY_D] <= w_act[PIN_DOWN];
                    r_word[JOY_L] <= w_act[PIN_LEFT];
                    r_word[JOY_R] <= w_act[PIN_RIGHT];
                    r_word[JOY_B] <= w_act[PIN_6];
                    r_word[JOY_C] <= w_act[PIN_9];
                end
                3'd1: begin
                    r_word[JOY_A]     <= w_act[PIN_6];
                    r_word[JOY_START] <= w_act[PIN_9];
                    r_present         <= w_act[PIN_LEFT] & w_act[PIN_RIGHT];
                end
                3'd3: begin
                    r_six <= w_act[PIN_UP] & w_act[PIN_DOWN] & w_act[PIN_LEFT] & w_act[PIN_RIGHT];
                end
                3'd4: begin
                    // r_six was captured at phase 3 of this same scan
                    r_word[JOY_Z]    <= r_six & w_act[PIN_UP];
                    r_word[JOY_Y]    <= r_six & w_act[PIN_DOWN];
                    r_word[JOY_X]    <= r_six & w_act[PIN_LEFT];
                    r_word[JOY_MODE] <= r_six & w_act[PIN_RIGHT];
                end
                default: ;
            endcase
        end
    end

    assign o_present = r_present;
    assign o_six     = r_present & r_six;
    assign o_word    = r_present ? {4'b0000, r_word} : 16'h0000;

endmodule

// File: rtl/joy_md_scanner.sv
// Megadrive DB9 splitter sequencer: steps SELECT and port select through the 8-phase
// 3/6-button protocol, samples both pads, and commits decoded words once per scan.
module joy_md_scanner
    import joy_pkg::*;
#(
    parameter int unsigned SETTLE   = 480,
    parameter int unsigned SCAN_GAP = 96000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [5:0]  i_joy_in,
    output logic        o_joy_split,
    output logic        o_joy_mdsel,
    output logic [15:0] o_joystick1,
    output logic [15:0] o_joystick2,
    output logic [1:0]  o_present,
    output logic [1:0]  o_six_btn,
    output logic        o_scan_done
);

    localparam int unsigned TW = $clog2(SETTLE > SCAN_GAP ? SETTLE : SCAN_GAP);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
    localparam logic [TW-1:0] GAP_LD    = TW'(SCAN_GAP - 1);
    // The COMMIT cycle already holds SELECT high, so the gap after it is one shorter
    localparam logic [TW-1:0] RESUME_LD = TW'(SCAN_GAP - 2);

    state_e       r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]   r_step;
    logic         r_mdsel;
    logic         r_split;
    logic [15:0]  r_joy1;
    logic [15:0]  r_joy2;
    logic [1:0]   r_present;
    logic [1:0]   r_six;
    logic         r_scan_done;
    logic [5:0]   r_sync1;
    logic [5:0]   r_sync2;

    logic         w_sample;
    logic [3:0]   w_step_nxt;
    logic [15:0]  w_word1;
    logic [15:0]  w_word2;
    logic         w_pres1;
    logic         w_pres2;
    logic         w_six1;
    logic         w_six2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 6'h3f;
            r_sync2 <= 6'h3f;
        end else begin
            r_sync1 <= i_joy_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample   = (r_state == StPhase) && (r_timer == '0);
    assign w_step_nxt = r_step + 4'd1;

    joy_md_decode u_dec1 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (~i_enable),
        .i_strobe  (w_sample & ~r_split),
        .i_phase   (r_step[3:1]),
        .i_pins    (r_sync2),
        .o_word    (w_word1),
        .o_present (w_pres1),
        .o_six     (w_six1)
    );

    joy_md_decode u_dec2 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (~i_enable),
        .i_strobe  (w_sample & r_split),
        .i_phase   (r_step[3:1]),
        .i_pins    (r_sync2),
        .o_word    (w_word2),
        .o_present (w_pres2),
        .o_six     (w_six2)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StGap;
            r_timer     <= GAP_LD;
            r_step      <= '0;
            r_mdsel     <= 1'b1;
            r_split     <= 1'b0;
            r_joy1      <= '0;
            r_joy2      <= '0;
            r_present   <= '0;
            r_six       <= '0;
            r_scan_done <= 1'b0;
        end else if (!i_enable) begin
            r_state     <= StGap;
            r_timer     <= GAP_LD;
            r_step      <= '0;
            r_mdsel     <= 1'b1;
            r_split     <= 1'b0;
            r_joy1      <= '0;
            r_joy2      <= '0;
            r_present   <= '0;
            r_six       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                StGap: begin
                    if (r_timer == '0) begin
                        r_state <= StPhase;
                        r_step  <= '0;
                        r_timer <= SETTLE_LD;
                        r_mdsel <= 1'b1;
                        r_split <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                StPhase: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (r_step == 4'd15) begin
                        r_state <= StCommit;
                        r_mdsel <= 1'b1;
                        r_split <= 1'b0;
                    end else begin
                        // step = {phase, port}; SELECT is high on even phases
                        r_step  <= w_step_nxt;
                        r_timer <= SETTLE_LD;
                        r_mdsel <= ~w_step_nxt[1];
                        r_split <= w_step_nxt[0];
                    end
                end
                StCommit: begin
                    r_joy1      <= w_word1;
                    r_joy2      <= w_word2;
                    r_present   <= {w_pres2, w_pres1};
                    r_six       <= {w_six2, w_six1};
                    r_scan_done <= 1'b1;
                    r_state     <= StGap;
                    r_timer     <= RESUME_LD;
                end
                default: begin
                    r_state <= StGap;
                    r_timer <= GAP_LD;
                end
            endcase
        end
    end

    assign o_joy_split = r_split;
    assign o_joy_mdsel = r_mdsel;
    assign o_joystick1 = r_joy1;
    assign o_joystick2 = r_joy2;
    assign o_present   = r_present;
    assign o_six_btn   = r_six;
    assign o_scan_done = r_scan_done;

endmodule

// File: tb/tb_joy_md_scanner.sv
// Scoreboard bench for joy_md_scanner with a behavioural two-pad splitter model.
module tb_joy_md_scanner;

    localparam int SETTLE = 4;
    localparam int GAP    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [5:0]  joy_in;
    logic        joy_split;
    logic        joy_mdsel;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [1:0]  present;
    logic [1:0]  six_btn;
    logic        scan_done;

    always #5 clk = ~clk;

    joy_md_scanner #(
        .SETTLE   (SETTLE),
        .SCAN_GAP (GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_joy_in    (joy_in),
        .o_joy_split (joy_split),
        .o_joy_mdsel (joy_mdsel),
        .o_joystick1 (joystick1),
        .o_joystick2 (joystick2),
        .o_present   (present),
        .o_six_btn   (six_btn),
        .o_scan_done (scan_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Pad model: phase counter advanced on each SELECT edge, cleared by a long SELECT high
    int          typ1 = 0;
    int          typ2 = 0;
    logic [15:0] btn1 = 16'h0;
    logic [15:0] btn2 = 16'h0;
    logic [2:0]  cnt = 3'd0;
    logic        last_sel = 1'b1;
    int          hi_run = 0;

    always @(posedge clk or joy_mdsel) begin
        if (joy_mdsel !== last_sel) begin
            cnt      = cnt + 3'd1;
            last_sel = joy_mdsel;
            hi_run   = 0;
        end else if (joy_mdsel === 1'b1) begin
            hi_run = hi_run + 1;
            if (hi_run >= 12) cnt = 3'd0;
        end
    end

    function automatic logic [5:0] pad_pins(input int typ, input logic [15:0] b,
                                            input logic [2:0] ph);
        logic [5:0] act;
        if (typ == 0) return 6'h3f;
        if (ph == 3'd4 && typ == 2) act = {b[6], b[5], b[11], b[8], b[9], b[10]};
        else if (!ph[0])            act = {b[6], b[5], b[0], b[1], b[2], b[3]};
        else if (ph == 3'd3 && typ == 2) act = {b[7], b[4], 4'b1111};
        else                        act = {b[7], b[4], 1'b1, 1'b1, b[2], b[3]};
        return ~act;
    endfunction

    assign joy_in = joy_split ? pad_pins(typ2, btn2, cnt) : pad_pins(typ1, btn1, cnt);

    // Scoreboard
    typedef struct packed {
        logic [15:0] j1;
        logic [15:0] j2;
        logic [1:0]  pr;
        logic [1:0]  sx;
    } exp_t;

    exp_t q[$];

    task automatic push(input logic [15:0] j1, input logic [15:0] j2,
                        input logic [1:0] pr, input logic [1:0] sx);
        exp_t e;
        e.j1 = j1; e.j2 = j2; e.pr = pr; e.sx = sx;
        q.push_back(e);
    endtask

    logic [35:0] prev_out = '0;
    logic        prev_en  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (scan_done === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_scan_done: got 1 expected 0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("joystick1", {16'h0, joystick1}, {16'h0, e.j1});
                    check("joystick2", {16'h0, joystick2}, {16'h0, e.j2});
                    check("present", {30'h0, present}, {30'h0, e.pr});
                    check("six_btn", {30'h0, six_btn}, {30'h0, e.sx});
                end
            end else if (prev_en && enable &&
                         prev_out != {joystick1, joystick2, present, six_btn}) begin
                n_err++;
                $display("FAIL outputs_outside_commit: got %h expected %h at %0t",
                         {joystick1, joystick2, present, six_btn}, prev_out, $time);
            end
        end
        prev_out = {joystick1, joystick2, present, six_btn};
        prev_en  = enable;
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (scan_done !== 1'b1 && n < 400);
        if (scan_done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL scan_done_timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic wait_phase(input logic [2:0] ph, input logic sp);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(cnt == ph && joy_split === sp) && k < 200);
        if (!(cnt == ph && joy_split === sp)) begin
            n_vec++;
            n_err++;
            $display("FAIL phase_timeout: got %0d expected %0d at %0t", cnt, ph, $time);
        end
    endtask

    task automatic apply_vec(input int t1, input logic [15:0] b1, input int t2,
                             input logic [15:0] b2, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [1:0] ep, input logic [1:0] es);
        int n;
        typ1 = t1; btn1 = b1; typ2 = t2; btn2 = b2;
        push(e1, e2, ep, es);
        push(e1, e2, ep, es);
        wait_done(n);
        wait_done(n);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mdsel", {31'h0, joy_mdsel}, 32'd1);
        check("rst_split", {31'h0, joy_split}, 32'd0);
        check("rst_joy", {joystick1, joystick2}, 32'h0);
        check("rst_flags", {28'h0, present, six_btn}, 32'h0);
        check("rst_done", {31'h0, scan_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_mdsel", {31'h0, joy_mdsel}, 32'd1);

        // No pads: first scan latency then steady period
        push(16'h0, 16'h0, 2'b00, 2'b00);
        push(16'h0, 16'h0, 2'b00, 2'b00);
        @(negedge clk);
        enable = 1'b1;
        wait_done(n);
        check("first_latency", n, 32'd73);
        wait_done(n);
        check("scan_period", n, 32'd72);

        apply_vec(1, 16'h0011, 0, 16'h0000, 16'h0011, 16'h0000, 2'b01, 2'b00);
        apply_vec(1, 16'h0011, 2, 16'h0C80, 16'h0011, 16'h0C80, 2'b11, 2'b10);
        apply_vec(1, 16'h0108, 0, 16'h0000, 16'h0008, 16'h0000, 2'b01, 2'b00);
        apply_vec(2, 16'h0FFF, 0, 16'h0000, 16'h0FFF, 16'h0000, 2'b01, 2'b01);
        apply_vec(2, 16'h0000, 1, 16'h0064, 16'h0000, 16'h0064, 2'b11, 2'b01);

        // Pin change after the p0 sample: this scan keeps Up, next shows Down
        typ1 = 1; btn1 = 16'h0008; typ2 = 0; btn2 = 16'h0;
        push(16'h0008, 16'h0, 2'b01, 2'b00);
        wait_phase(3'd1, 1'b0);
        btn1 = 16'h0004;
        push(16'h0004, 16'h0, 2'b01, 2'b00);
        wait_done(n);
        wait_done(n);

        // SELECT / split waveform across one scan
        push(16'h0004, 16'h0, 2'b01, 2'b00);
        push(16'h0004, 16'h0, 2'b01, 2'b00);
        repeat (GAP - 1) @(posedge clk);
        for (int k = 0; k < 16 * SETTLE; k++) begin
            #1;
            check("wave_mdsel", {31'h0, joy_mdsel}, {31'h0, ((k / 8) % 2 == 0)});
            check("wave_split", {31'h0, joy_split}, {31'h0, ((k / 4) % 2 == 1)});
            @(posedge clk);
        end
        #1;
        check("commit_mdsel", {31'h0, joy_mdsel}, 32'd1);
        wait_done(n);
        check("commit_to_done", n, 32'd1);
        wait_done(n);
        check("period_again", n, 32'd72);

        // Abort at PH(3,1)
        wait_phase(3'd3, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mdsel", {31'h0, joy_mdsel}, 32'd1);
        check("abort_split", {31'h0, joy_split}, 32'd0);
        check("abort_joy", {joystick1, joystick2}, 32'h0);
        check("abort_flags", {28'h0, present, six_btn}, 32'h0);
        check("abort_done", {31'h0, scan_done}, 32'd0);
        repeat (6) @(posedge clk);
        push(16'h0004, 16'h0, 2'b01, 2'b00);
        @(negedge clk);
        enable = 1'b1;
        wait_done(n);
        check("reenable_latency", n, 32'd73);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
